// File: rtl/mp_fifo_pkg.sv
// Shared types and helper functions for the multi-port FIFO.
package mp_fifo_pkg;

  // Widest lane vector supported by the helpers (both port counts are 1..4)
  localparam int MAX_LANES = 4;

  typedef logic [MAX_LANES-1:0] lane_vec_t;
  typedef logic [2:0]           lane_cnt_t;

  // Pointer width: one extra bit above the address so full and empty differ
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Number of set bits in a lane vector
  function automatic lane_cnt_t popcount(input lane_vec_t v);
    lane_cnt_t c;
    c = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      c = c + lane_cnt_t'(v[i]);
    end
    return c;
  endfunction

  // Length of the unbroken run of set bits starting at bit 0
  function automatic lane_cnt_t thermo_prefix_len(input lane_vec_t v);
    lane_cnt_t c;
    logic      run;
    c   = '0;
    run = 1'b1;
    for (int i = 0; i < MAX_LANES; i++) begin
      run = run & v[i];
      c   = c + lane_cnt_t'(run);
    end
    return c;
  endfunction

endpackage

// File: rtl/mp_fifo_regfile.sv
// FIFO storage: multi-write-port register array with combinational reads.
// Write addresses within one cycle are distinct, so no collision handling.
module mp_fifo_regfile
  import mp_fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = 16,
  parameter int NUM_WR_PORTS = 2,
  parameter int NUM_RD_PORTS = 2
) (
  input  logic                                  clk,
  input  logic [NUM_WR_PORTS-1:0]               we,
  input  logic [NUM_WR_PORTS*$clog2(DEPTH)-1:0] waddr,
  input  logic [NUM_WR_PORTS*DATA_WIDTH-1:0]    wdata,
  input  logic [NUM_RD_PORTS*$clog2(DEPTH)-1:0] raddr,
  output logic [NUM_RD_PORTS*DATA_WIDTH-1:0]    rdata
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Store every enabled write lane into its slot (contents are never reset)
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_WR_PORTS; k++) begin
      if (we[k]) begin
        mem[waddr[k*AW +: AW]] <= wdata[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Combinational read of each lane's addressed slot
  always_comb begin
    rdata = '0;
    for (int j = 0; j < NUM_RD_PORTS; j++) begin
      rdata[j*DATA_WIDTH +: DATA_WIDTH] = mem[raddr[j*AW +: AW]];
    end
  end

endmodule

// File: rtl/mp_fifo.sv
// Multi-port synchronous FIFO with lane compaction, FWFT reads, occupancy
// flags, synchronous flush and sticky overflow/underflow flags.
module mp_fifo
  import mp_fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = 16,
  parameter int NUM_WR_PORTS = 2,
  parameter int NUM_RD_PORTS = 2,
  parameter int AF_THRESH    = DEPTH - 4,
  parameter int AE_THRESH    = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush,
  input  logic [NUM_WR_PORTS-1:0]            wr_en,
  input  logic [NUM_WR_PORTS*DATA_WIDTH-1:0] wr_data,
  output logic [NUM_WR_PORTS-1:0]            wr_ack,
  input  logic [NUM_RD_PORTS-1:0]            rd_en,
  output logic [NUM_RD_PORTS-1:0]            rd_valid,
  output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rd_data,
  output logic [$clog2(DEPTH):0]             count,
  output logic                               full,
  output logic                               empty,
  output logic                               almost_full,
  output logic                               almost_empty,
  output logic                               overflow,
  output logic                               underflow
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = $clog2(DEPTH);

  localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
  localparam logic [PW-1:0] AF_C    = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE_C    = PW'(AE_THRESH);

  logic [PW-1:0]                wr_ptr;
  logic [PW-1:0]                rd_ptr;
  logic [PW-1:0]                count_q;
  logic [PW-1:0]                free_slots;
  logic [PW-1:0]                wr_rank;
  logic [NUM_WR_PORTS*AW-1:0]   wr_addr;
  logic [NUM_RD_PORTS*AW-1:0]   rd_addr;
  logic [NUM_RD_PORTS-1:0]      pop_mask;
  lane_vec_t                    ack_vec;
  lane_vec_t                    pop_req;
  lane_cnt_t                    n_wr;
  lane_cnt_t                    n_rd;
  logic                         ovf_ev;
  logic                         udf_ev;

  // Space is judged on the registered count only: same-cycle pops do not help
  assign free_slots = DEPTH_C - count_q;

  // Write compaction: each requesting lane takes the next free slot in lane order.
  // Acks are held low in reset so no write can land while rst is asserted.
  always_comb begin
    wr_rank = '0;
    wr_ack  = '0;
    wr_addr = '0;
    for (int k = 0; k < NUM_WR_PORTS; k++) begin
      wr_ack[k] = rst && !flush && wr_en[k] && (wr_rank < free_slots);
      wr_addr[k*AW +: AW] = wr_ptr[AW-1:0] + wr_rank[AW-1:0];
      wr_rank = wr_rank + PW'(wr_en[k]);
    end
  end

  // Read lanes present entries head+j; a lane is valid while count exceeds its index
  always_comb begin
    rd_valid = '0;
    rd_addr  = '0;
    pop_req  = '0;
    for (int j = 0; j < NUM_RD_PORTS; j++) begin
      rd_valid[j] = count_q > PW'(j);
      rd_addr[j*AW +: AW] = rd_ptr[AW-1:0] + AW'(j);
      pop_req[j] = rd_en[j] && rd_valid[j];
    end
  end

  assign n_rd = flush ? '0 : thermo_prefix_len(pop_req);

  // Lanes actually popped this cycle (the thermometer prefix)
  always_comb begin
    pop_mask = '0;
    for (int j = 0; j < NUM_RD_PORTS; j++) begin
      pop_mask[j] = lane_cnt_t'(j) < n_rd;
    end
  end

  // Widen the ack vector to the helper's lane width before counting
  always_comb begin
    ack_vec = '0;
    ack_vec[NUM_WR_PORTS-1:0] = wr_ack;
  end

  assign n_wr   = popcount(ack_vec);
  assign ovf_ev = |(wr_en & ~wr_ack);
  assign udf_ev = |(rd_en & ~pop_mask);

  // Pointers and occupancy; flush empties the FIFO and discards this cycle's traffic
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      wr_ptr  <= wr_ptr + PW'(n_wr);
      rd_ptr  <= rd_ptr + PW'(n_rd);
      count_q <= count_q + PW'(n_wr) - PW'(n_rd);
    end
  end

  // Sticky error flags, cleared only by reset (flush leaves them alone)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_ev) overflow  <= 1'b1;
      if (udf_ev) underflow <= 1'b1;
    end
  end

  assign count        = count_q;
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);

  mp_fifo_regfile #(
    .DATA_WIDTH  (DATA_WIDTH),
    .DEPTH       (DEPTH),
    .NUM_WR_PORTS(NUM_WR_PORTS),
    .NUM_RD_PORTS(NUM_RD_PORTS)
  ) u_regfile (
    .clk  (clk),
    .we   (wr_ack),
    .waddr(wr_addr),
    .wdata(wr_data),
    .raddr(rd_addr),
    .rdata(rd_data)
  );

endmodule

// File: tb/tb_mp_fifo.sv
// Bench for mp_fifo: queue-based reference model checked every cycle,
// plus hand-computed literal expectations for the directed scenarios.
module tb_mp_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int NW    = 2;
  localparam int NR    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [1:0]  wr_en;
  logic [15:0] wr_data;
  logic [1:0]  wr_ack;
  logic [1:0]  rd_en;
  logic [1:0]  rd_valid;
  logic [15:0] rd_data;
  logic [4:0]  count;
  logic        full, empty, almost_full, almost_empty, overflow, underflow;

  int nvec = 0;
  int nerr = 0;

  // Reference model: FIFO contents as a queue plus the two sticky flags
  logic [7:0] mq[$];
  bit         m_ovf;
  bit         m_udf;

  always #10 clk = ~clk;

  mp_fifo #(
    .DATA_WIDTH  (DW),
    .DEPTH       (DEPTH),
    .NUM_WR_PORTS(NW),
    .NUM_RD_PORTS(NR),
    .AF_THRESH   (12),
    .AE_THRESH   (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .wr_ack      (wr_ack),
    .rd_en       (rd_en),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Compare all DUT outputs against the model for the inputs currently applied
  task automatic model_check();
    int         cnt;
    int         e;
    logic [1:0] eack;
    logic [1:0] evld;
    cnt  = mq.size();
    e    = 0;
    eack = '0;
    evld = '0;
    for (int k = 0; k < NW; k++) begin
      if (wr_en[k] && !flush && e < DEPTH - cnt) eack[k] = 1'b1;
      if (wr_en[k]) e++;
    end
    for (int j = 0; j < NR; j++) evld[j] = (cnt > j);
    cmp("wr_ack", wr_ack, eack);
    cmp("rd_valid", rd_valid, evld);
    cmp("count", count, cnt);
    cmp("full", full, cnt == DEPTH);
    cmp("empty", empty, cnt == 0);
    cmp("almost_full", almost_full, cnt >= 12);
    cmp("almost_empty", almost_empty, cnt <= 2);
    cmp("overflow", overflow, m_ovf);
    cmp("underflow", underflow, m_udf);
    for (int j = 0; j < NR; j++) begin
      if (j < cnt) cmp($sformatf("rd_data%0d", j), rd_data[j*DW +: DW], mq[j]);
    end
  endtask

  // Apply one cycle of stimulus, check before the edge, advance the model after it
  task automatic step(input logic f, input logic [1:0] we, input logic [15:0] wd,
                      input logic [1:0] re);
    int         cnt;
    int         e;
    int         npop;
    logic [7:0] pushq[$];
    bit         novf;
    bit         nudf;
    flush   = f;
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    #3;
    model_check();
    cnt  = mq.size();
    e    = 0;
    novf = m_ovf;
    nudf = m_udf;
    for (int k = 0; k < NW; k++) begin
      if (we[k]) begin
        if (!f && e < DEPTH - cnt) pushq.push_back(wd[k*DW +: DW]);
        else novf = 1'b1;
        e++;
      end
    end
    npop = 0;
    if (!f) begin
      while (npop < NR && re[npop] && npop < cnt) npop++;
    end
    for (int j = 0; j < NR; j++) if (re[j] && j >= npop) nudf = 1'b1;
    @(posedge clk);
    if (f) begin
      mq.delete();
    end else begin
      repeat (npop) void'(mq.pop_front());
      foreach (pushq[i]) mq.push_back(pushq[i]);
    end
    m_ovf = novf;
    m_udf = nudf;
    #1;
  endtask

  task automatic check_reset(input string tag);
    cmp({tag, "_count"}, count, 0);
    cmp({tag, "_empty"}, empty, 1);
    cmp({tag, "_full"}, full, 0);
    cmp({tag, "_ae"}, almost_empty, 1);
    cmp({tag, "_af"}, almost_full, 0);
    cmp({tag, "_ovf"}, overflow, 0);
    cmp({tag, "_udf"}, underflow, 0);
    cmp({tag, "_rd_valid"}, rd_valid, 0);
    cmp({tag, "_wr_ack"}, wr_ack, 0);
  endtask

  // Assert reset between edges, check immediately, then release on a falling edge
  task automatic do_reset(input string tag);
    rst = 1'b0;
    #1;
    mq.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    check_reset(tag);
    flush   = 1'b0;
    wr_en   = '0;
    rd_en   = '0;
    wr_data = '0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [1:0] we;
    logic [1:0] re;
    logic [7:0] a;
    rst     = 1'b0;
    flush   = 1'b0;
    wr_en   = '0;
    rd_en   = '0;
    wr_data = '0;

    // 1: reset, then a two-lane push visible next cycle
    do_reset("rst0");
    step(0, 2'b11, 16'hB1A0, 2'b00);
    #1;
    cmp("s1_count", count, 2);
    cmp("s1_lane0", rd_data[7:0], 8'hA0);
    cmp("s1_lane1", rd_data[15:8], 8'hB1);
    cmp("s1_valid", rd_valid, 2'b11);
    cmp("s1_ae", almost_empty, 1);
    step(0, 2'b00, 16'h0000, 2'b11);

    // 2: compaction of a lone lane-1 write into slot 0
    step(0, 2'b10, 16'h5500, 2'b00);
    #1;
    cmp("s2_lane0", rd_data[7:0], 8'h55);
    cmp("s2_valid", rd_valid, 2'b01);
    step(0, 2'b00, 16'h0000, 2'b01);

    // 3: fill to 15, then a two-lane push only fits lane 0
    for (int i = 0; i < 7; i++) begin
      a = 8'(2 * i + 16);
      step(0, 2'b11, {a + 8'd1, a}, 2'b00);
    end
    step(0, 2'b01, 16'h001E, 2'b00);
    flush   = 1'b0;
    wr_en   = 2'b11;
    wr_data = 16'h0201;
    rd_en   = 2'b00;
    #1;
    cmp("s3_ack", wr_ack, 2'b01);
    step(0, 2'b11, 16'h0201, 2'b00);
    #1;
    cmp("s3_count", count, 16);
    cmp("s3_full", full, 1);
    cmp("s3_ovf", overflow, 1);
    step(0, 2'b00, 16'h0000, 2'b00);
    step(0, 2'b00, 16'h0000, 2'b00);
    #1;
    cmp("s3_ovf_sticky", overflow, 1);

    // 4: full FIFO, simultaneous pops and pushes (no bypass), then mixed traffic
    step(0, 2'b11, 16'hC3C2, 2'b11);
    #1;
    cmp("s4_count_a", count, 14);
    step(0, 2'b11, 16'hC5C4, 2'b11);
    #1;
    cmp("s4_count_b", count, 14);
    for (int i = 0; i < 40; i++) begin
      case (i % 3)
        0:       we = 2'b11;
        1:       we = 2'b10;
        default: we = 2'b01;
      endcase
      case (i % 5)
        0:       re = 2'b11;
        1:       re = 2'b01;
        2:       re = 2'b00;
        3:       re = 2'b11;
        default: re = 2'b11;
      endcase
      a = 8'(2 * i + 8'h40);
      step(0, we, {a + 8'd1, a}, re);
    end

    // 5: underflow on an invalid lane, then on a non-thermometer request
    do_reset("rst1");
    step(0, 2'b01, 16'h0011, 2'b00);
    step(0, 2'b00, 16'h0000, 2'b11);
    #1;
    cmp("s5_udf_a", underflow, 1);
    cmp("s5_count_a", count, 0);
    cmp("s5_empty", empty, 1);
    do_reset("rst2");
    step(0, 2'b11, 16'h2120, 2'b00);
    step(0, 2'b11, 16'h2322, 2'b00);
    step(0, 2'b01, 16'h0024, 2'b00);
    step(0, 2'b00, 16'h0000, 2'b10);
    #1;
    cmp("s5_count_b", count, 5);
    cmp("s5_udf_b", underflow, 1);
    cmp("s5_head", rd_data[7:0], 8'h20);

    // 6: flush overrides a push, then asynchronous reset mid-push
    step(0, 2'b11, 16'h2625, 2'b00);
    step(0, 2'b11, 16'h2827, 2'b00);
    #1;
    cmp("s6_count9", count, 9);
    flush   = 1'b1;
    wr_en   = 2'b11;
    wr_data = 16'hEEDD;
    rd_en   = 2'b00;
    #1;
    cmp("s6_flush_ack", wr_ack, 2'b00);
    step(1, 2'b11, 16'hEEDD, 2'b00);
    #1;
    cmp("s6_count0", count, 0);
    flush   = 1'b0;
    wr_en   = 2'b11;
    wr_data = 16'h7766;
    #1;
    cmp("s6_ack_live", wr_ack, 2'b11);
    do_reset("rst_mid");
    step(0, 2'b01, 16'h0077, 2'b00);
    #1;
    cmp("s6_slot0", rd_data[7:0], 8'h77);
    cmp("s6_count1", count, 1);
    step(0, 2'b00, 16'h0000, 2'b01);
    step(0, 2'b00, 16'h0000, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
